// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller.
// Holds the codebase-wide control-bus and FSM-state defines plus the typed views
// (ctrl_t, pipe_state_e, ctrl_bus_t) and the per-hazard output patterns built on them.

`ifndef PIPE_CTRL_DEFINES
`define PIPE_CTRL_DEFINES
`define CTRL_Wire_Bus logic [1:0]
`define CTRL_STATE_Default 2'b00
`define CTRL_STATE_Stalled 2'b01
`define CTRL_STATE_Bubble 2'b10
`define PIPE_STATE_Run 2'b00
`define PIPE_STATE_Drain 2'b01
`define PIPE_STATE_MemWait 2'b10
`endif

package pipe_ctrl_pkg;

  typedef `CTRL_Wire_Bus ctrl_t;

  localparam ctrl_t CtrlDefault = `CTRL_STATE_Default;
  localparam ctrl_t CtrlStalled = `CTRL_STATE_Stalled;
  localparam ctrl_t CtrlBubble  = `CTRL_STATE_Bubble;

  typedef enum logic [1:0] {
    StRun     = `PIPE_STATE_Run,
    StDrain   = `PIPE_STATE_Drain,
    StMemWait = `PIPE_STATE_MemWait
  } pipe_state_e;

  typedef struct packed {
    ctrl_t pc;
    ctrl_t if_id;
    ctrl_t id_ex;
    ctrl_t ex_mem;
    ctrl_t mem_wb;
  } ctrl_bus_t;

  localparam ctrl_bus_t AllDefault = '{CtrlDefault, CtrlDefault, CtrlDefault, CtrlDefault,
                                       CtrlDefault};
  localparam ctrl_bus_t AllBubble  = '{CtrlBubble, CtrlBubble, CtrlBubble, CtrlBubble,
                                       CtrlBubble};
  // Memory wait: freeze everything upstream of MEM, feed a bubble into WB.
  localparam ctrl_bus_t BusyCtrl   = '{CtrlStalled, CtrlStalled, CtrlStalled, CtrlStalled,
                                       CtrlBubble};
  // Redirect: squash the two wrong-path instructions in IF/ID and ID/EX.
  localparam ctrl_bus_t FlushCtrl  = '{CtrlDefault, CtrlBubble, CtrlBubble, CtrlDefault,
                                       CtrlDefault};
  // Hold front end, insert a bubble behind it (load-use and fence drain alike).
  localparam ctrl_bus_t HoldCtrl   = '{CtrlStalled, CtrlStalled, CtrlBubble, CtrlDefault,
                                       CtrlDefault};

  function automatic logic any_stalled(input ctrl_bus_t c);
    return (c.pc == CtrlStalled) || (c.if_id == CtrlStalled) || (c.id_ex == CtrlStalled) ||
           (c.ex_mem == CtrlStalled) || (c.mem_wb == CtrlStalled);
  endfunction

endpackage

// File: rtl/perf_cnt32.sv
// 32-bit wrapping event counter.
// Ports: clk (clock), rst (async active-low reset), inc_i (count this cycle),
//        cnt_o (current count).

module perf_cnt32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller.
// Ports: clk, rst (async active-low); hazard inputs load_use_i, branch_taken_i, mem_busy_i,
//        fence_i; per-stage controls ctrl_pc_o .. ctrl_mem_wb_o (Default/Stalled/Bubble);
//        mem_timeout_o one-cycle pulse; stall_cnt_o / flush_cnt_o performance counters.
// Controls are combinational from current state and inputs.

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use_i,
  input  logic        branch_taken_i,
  input  logic        mem_busy_i,
  input  logic        fence_i,
  output ctrl_t       ctrl_pc_o,
  output ctrl_t       ctrl_if_id_o,
  output ctrl_t       ctrl_id_ex_o,
  output ctrl_t       ctrl_ex_mem_o,
  output ctrl_t       ctrl_mem_wb_o,
  output logic        mem_timeout_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int unsigned ToW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned DrW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [ToW-1:0] ToMax  = ToW'(MEM_TIMEOUT);
  localparam logic [DrW-1:0] DrLast = DrW'(DRAIN_CYCLES - 1);

  pipe_state_e    state_q, state_d, eff_state;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic [DrW-1:0] drain_cnt_q, drain_cnt_d;
  logic           from_drain_q, from_drain_d;
  ctrl_bus_t      ctrl;
  logic           timeout;
  logic           flush_inc;

  always_comb begin
    // A MEM_WAIT cycle whose busy has dropped behaves as the state it returns to, so a
    // drain interrupted by memory resumes without an idle cycle in between.
    eff_state = state_q;
    if (state_q == StMemWait && !mem_busy_i) begin
      eff_state = from_drain_q ? StDrain : StRun;
    end
    state_d      = eff_state;
    to_cnt_d     = '0;
    drain_cnt_d  = drain_cnt_q;
    from_drain_d = from_drain_q;
    ctrl         = AllDefault;
    timeout      = 1'b0;
    flush_inc    = 1'b0;

    if (mem_busy_i) begin
      ctrl = BusyCtrl;
      if (state_q == StMemWait) begin
        to_cnt_d = (to_cnt_q == ToMax) ? ToMax : to_cnt_q + ToW'(1);
        // Saturation keeps the counter at ToMax, so this fires once per episode.
        timeout  = (to_cnt_q != ToMax) && (to_cnt_d == ToMax);
      end else begin
        state_d      = StMemWait;
        from_drain_d = (state_q == StDrain);
        to_cnt_d     = ToW'(1);
        timeout      = (ToMax == ToW'(1));
      end
    end else if (branch_taken_i) begin
      ctrl         = FlushCtrl;
      flush_inc    = 1'b1;
      state_d      = StRun;
      drain_cnt_d  = '0;
      from_drain_d = 1'b0;
    end else if (eff_state == StDrain) begin
      ctrl = HoldCtrl;
      if (drain_cnt_q >= DrLast) begin
        state_d     = StRun;
        drain_cnt_d = '0;
      end else begin
        drain_cnt_d = drain_cnt_q + DrW'(1);
      end
    end else if (fence_i) begin
      // The entry cycle is the first drain cycle.
      ctrl = HoldCtrl;
      if (DRAIN_CYCLES > 1) begin
        state_d     = StDrain;
        drain_cnt_d = DrW'(1);
      end
    end else if (load_use_i) begin
      ctrl = HoldCtrl;
    end

    if (!rst) begin
      ctrl    = AllBubble;
      timeout = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StRun;
      to_cnt_q     <= '0;
      drain_cnt_q  <= '0;
      from_drain_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      from_drain_q <= from_drain_d;
    end
  end

  assign ctrl_pc_o     = ctrl.pc;
  assign ctrl_if_id_o  = ctrl.if_id;
  assign ctrl_id_ex_o  = ctrl.id_ex;
  assign ctrl_ex_mem_o = ctrl.ex_mem;
  assign ctrl_mem_wb_o = ctrl.mem_wb;
  assign mem_timeout_o = timeout;

  perf_cnt32 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (any_stalled(ctrl)),
    .cnt_o (stall_cnt_o)
  );

  perf_cnt32 u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change at the falling edge, outputs are
// checked 1 ns later, well away from the rising edge.

module tb_pipe_ctrl;

  localparam logic [9:0] ALL_D = 10'b00_00_00_00_00;
  localparam logic [9:0] ALL_B = 10'b10_10_10_10_10;
  localparam logic [9:0] BUSY  = 10'b01_01_01_01_10;
  localparam logic [9:0] FLUSH = 10'b00_10_10_00_00;
  localparam logic [9:0] HOLD  = 10'b01_01_10_00_00;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_use_i, branch_taken_i, mem_busy_i, fence_i;
  logic [1:0]  ctrl_pc_o, ctrl_if_id_o, ctrl_id_ex_o, ctrl_ex_mem_o, ctrl_mem_wb_o;
  logic        mem_timeout_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;
  logic [9:0]  ctrl_all;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  always #5 clk = ~clk;

  assign ctrl_all = {ctrl_pc_o, ctrl_if_id_o, ctrl_id_ex_o, ctrl_ex_mem_o, ctrl_mem_wb_o};

  pipe_ctrl #(
    .MEM_TIMEOUT  (255),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load_use_i     (load_use_i),
    .branch_taken_i (branch_taken_i),
    .mem_busy_i     (mem_busy_i),
    .fence_i        (fence_i),
    .ctrl_pc_o      (ctrl_pc_o),
    .ctrl_if_id_o   (ctrl_if_id_o),
    .ctrl_id_ex_o   (ctrl_id_ex_o),
    .ctrl_ex_mem_o  (ctrl_ex_mem_o),
    .ctrl_mem_wb_o  (ctrl_mem_wb_o),
    .mem_timeout_o  (mem_timeout_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  // Advance to the next falling edge, apply inputs, settle.
  task automatic drive(input logic lu, input logic br, input logic mb, input logic fe);
    @(negedge clk);
    load_use_i     = lu;
    branch_taken_i = br;
    mem_busy_i     = mb;
    fence_i        = fe;
    #1;
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl_all !== ALL_B) begin
      n_err++; $display("FAIL reset_ctrl: got %b want %b", ctrl_all, ALL_B);
    end
    n_cmp++;
    if ({mem_timeout_o, stall_cnt_o, flush_cnt_o} !== 65'd0) begin
      n_err++; $display("FAIL reset_regs: got to=%b st=%0d fl=%0d want all 0",
                        mem_timeout_o, stall_cnt_o, flush_cnt_o);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ctrl_all !== ALL_D) begin
      n_err++; $display("FAIL reset_release: got %b want %b", ctrl_all, ALL_D);
    end
  endtask

  task automatic test_load_use;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl_all !== HOLD) begin
      n_err++; $display("FAIL load_use_ctrl: got %b want %b", ctrl_all, HOLD);
    end
    exp_stall += 1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl_all !== ALL_D) begin
      n_err++; $display("FAIL load_use_after: got %b want %b", ctrl_all, ALL_D);
    end
    n_cmp++;
    if (stall_cnt_o !== exp_stall) begin
      n_err++; $display("FAIL load_use_stall_cnt: got %0d want %0d", stall_cnt_o, exp_stall);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (ctrl_all !== HOLD) begin
        n_err++; $display("FAIL b2b_ctrl[%0d]: got %b want %b", i, ctrl_all, HOLD);
      end
    end
    exp_stall += 2;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (stall_cnt_o !== exp_stall) begin
      n_err++; $display("FAIL b2b_stall_cnt: got %0d want %0d", stall_cnt_o, exp_stall);
    end
  endtask

  task automatic test_branch_fence;
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (ctrl_all !== FLUSH) begin
      n_err++; $display("FAIL br_fence_ctrl: got %b want %b", ctrl_all, FLUSH);
    end
    exp_flush += 1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl_all !== ALL_D) begin
      n_err++; $display("FAIL br_fence_stays_run: got %b want %b", ctrl_all, ALL_D);
    end
    n_cmp++;
    if (flush_cnt_o !== exp_flush || stall_cnt_o !== exp_stall) begin
      n_err++; $display("FAIL br_fence_cnts: got fl=%0d st=%0d want fl=%0d st=%0d",
                        flush_cnt_o, stall_cnt_o, exp_flush, exp_stall);
    end
  endtask

  // fence_i held through the drain must not extend it.
  task automatic test_drain_plain;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (ctrl_all !== HOLD) begin
        n_err++; $display("FAIL drain_ctrl[%0d]: got %b want %b", i, ctrl_all, HOLD);
      end
    end
    exp_stall += 3;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl_all !== ALL_D) begin
      n_err++; $display("FAIL drain_end: got %b want %b", ctrl_all, ALL_D);
    end
    n_cmp++;
    if (stall_cnt_o !== exp_stall) begin
      n_err++; $display("FAIL drain_stall_cnt: got %0d want %0d", stall_cnt_o, exp_stall);
    end
  endtask

  task automatic test_drain_abort;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl_all !== FLUSH) begin
      n_err++; $display("FAIL abort_ctrl: got %b want %b", ctrl_all, FLUSH);
    end
    exp_stall += 1;
    exp_flush += 1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl_all !== ALL_D) begin
      n_err++; $display("FAIL abort_run: got %b want %b", ctrl_all, ALL_D);
    end
    n_cmp++;
    if (flush_cnt_o !== exp_flush || stall_cnt_o !== exp_stall) begin
      n_err++; $display("FAIL abort_cnts: got fl=%0d st=%0d want fl=%0d st=%0d",
                        flush_cnt_o, stall_cnt_o, exp_flush, exp_stall);
    end
  endtask

  task automatic test_drain_mem;
    logic [9:0] exp_seq [6];
    exp_seq = '{HOLD, BUSY, BUSY, HOLD, HOLD, ALL_D};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, (i == 1 || i == 2), (i == 0));
      n_cmp++;
      if (ctrl_all !== exp_seq[i]) begin
        n_err++; $display("FAIL drain_mem_ctrl[%0d]: got %b want %b", i, ctrl_all, exp_seq[i]);
      end
    end
    exp_stall += 5;
    n_cmp++;
    if (stall_cnt_o !== exp_stall) begin
      n_err++; $display("FAIL drain_mem_stall_cnt: got %0d want %0d", stall_cnt_o, exp_stall);
    end
  endtask

  task automatic test_timeout;
    for (int k = 1; k <= 260; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (ctrl_all !== BUSY || mem_timeout_o !== (k == 255)) begin
        n_err++; $display("FAIL timeout_cycle%0d: got ctrl=%b to=%b want ctrl=%b to=%b",
                          k, ctrl_all, mem_timeout_o, BUSY, (k == 255));
      end
    end
    exp_stall += 260;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl_all !== ALL_D || mem_timeout_o !== 1'b0) begin
      n_err++; $display("FAIL timeout_after: got ctrl=%b to=%b want ctrl=%b to=0",
                        ctrl_all, mem_timeout_o, ALL_D);
    end
    n_cmp++;
    if (stall_cnt_o !== exp_stall) begin
      n_err++; $display("FAIL timeout_stall_cnt: got %0d want %0d", stall_cnt_o, exp_stall);
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 1; k <= 100; k++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ctrl_all !== ALL_B || mem_timeout_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_ctrl: got ctrl=%b to=%b want ctrl=%b to=0",
                        ctrl_all, mem_timeout_o, ALL_B);
    end
    n_cmp++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      n_err++; $display("FAIL rst_mid_cnts: got st=%0d fl=%0d want 0 0", stall_cnt_o, flush_cnt_o);
    end
    exp_stall = 0;
    exp_flush = 0;
    @(negedge clk);
    rst        = 1'b1;
    mem_busy_i = 1'b0;
    #1;
    n_cmp++;
    if (ctrl_all !== ALL_D || stall_cnt_o !== 32'd0) begin
      n_err++; $display("FAIL rst_mid_release: got ctrl=%b st=%0d want ctrl=%b st=0",
                        ctrl_all, stall_cnt_o, ALL_D);
    end
    // A timeout counter surviving reset at 100 would pulse at busy cycle 155.
    for (int k = 1; k <= 160; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (mem_timeout_o !== 1'b0 || ctrl_all !== BUSY) begin
        n_err++; $display("FAIL rst_mid_busy%0d: got ctrl=%b to=%b want ctrl=%b to=0",
                          k, ctrl_all, mem_timeout_o, BUSY);
      end
    end
    exp_stall += 160;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl_all !== ALL_D || stall_cnt_o !== exp_stall) begin
      n_err++; $display("FAIL rst_mid_final: got ctrl=%b st=%0d want ctrl=%b st=%0d",
                        ctrl_all, stall_cnt_o, ALL_D, exp_stall);
    end
  endtask

  initial begin
    rst            = 1'b0;
    load_use_i     = 1'b0;
    branch_taken_i = 1'b0;
    mem_busy_i     = 1'b0;
    fence_i        = 1'b0;
    test_reset();
    test_load_use();
    test_back_to_back();
    test_branch_fence();
    test_drain_plain();
    test_drain_abort();
    test_drain_mem();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
